// File: rtl/addr_map_cfg_ctrl.sv
// Run-time configuration controller for the dynamic address decoder: a shadow rule
// table filled over a valid/ready port and copied atomically to the active map on commit.
module addr_map_cfg_ctrl #(
    parameter int NoRules        = 4,
    parameter int AddrWidth      = 32,
    parameter int IdxWidth       = 3,
    parameter int MaxOutstanding = 15,
    parameter int DrainTimeout   = 256,
    localparam int RuleW         = (NoRules > 1) ? $clog2(NoRules) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [RuleW-1:0]              cfg_rule_i,
    input  logic [AddrWidth-1:0]          cfg_start_i,
    input  logic [AddrWidth-1:0]          cfg_end_i,
    input  logic [IdxWidth-1:0]           cfg_idx_i,
    output logic                          cfg_err_o,
    input  logic                          commit_i,
    output logic                          commit_done_o,
    output logic                          timeout_o,
    input  logic                          txn_start_i,
    input  logic                          txn_end_i,
    output logic                          config_ongoing_o,
    output logic [NoRules*AddrWidth-1:0]  map_start_o,
    output logic [NoRules*AddrWidth-1:0]  map_end_o,
    output logic [NoRules*IdxWidth-1:0]   map_idx_o,
    output logic                          busy_o
);

    localparam int CntW   = $clog2(MaxOutstanding + 1);
    localparam int TimerW = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;
    localparam logic [CntW-1:0]   CntMax    = CntW'(MaxOutstanding);
    localparam logic [TimerW-1:0] TimerLast = TimerW'((DrainTimeout > 0) ? DrainTimeout - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COPY,
        ST_SETTLE
    } state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [CntW-1:0]     cnt_d;
    logic [TimerW-1:0]   timer_q;
    logic                to_flag_q;
    logic                ongoing_q;
    logic                done_q;
    logic                timeout_q;
    logic                err_q;
    logic                wr_accept;
    logic                rule_in_range;
    logic                drain_expired;

    assign cfg_ready_o      = (state_q == ST_IDLE) && !rst_i;
    assign wr_accept        = cfg_valid_i && cfg_ready_o;
    assign rule_in_range    = int'(cfg_rule_i) < NoRules;
    assign drain_expired    = (DrainTimeout != 0) && (timer_q == TimerLast);
    assign cfg_err_o        = err_q;
    assign commit_done_o    = done_q;
    assign timeout_o        = timeout_q;
    assign config_ongoing_o = ongoing_q;
    assign busy_o           = (state_q != ST_IDLE);

    // In-flight counter: simultaneous start/end cancel; saturates at both ends.
    always_comb begin
        cnt_d = cnt_q;
        if (txn_start_i && !txn_end_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (txn_end_i && !txn_start_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= wr_accept && !rule_in_range;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            to_flag_q <= 1'b0;
            ongoing_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (commit_i) begin
                        state_q   <= ST_DRAIN;
                        timer_q   <= '0;
                        ongoing_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // A drain that empties on the last timer cycle is not a timeout.
                    if (cnt_d == '0) begin
                        state_q <= ST_COPY;
                    end else if (drain_expired) begin
                        state_q   <= ST_COPY;
                        to_flag_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                ST_COPY: begin
                    state_q   <= ST_SETTLE;
                    done_q    <= 1'b1;
                    timeout_q <= to_flag_q;
                    to_flag_q <= 1'b0;
                end
                ST_SETTLE: begin
                    state_q   <= ST_IDLE;
                    ongoing_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    ongoing_q <= 1'b0;
                end
            endcase
        end
    end

    // Per-rule shadow/active storage; all-ones start/end is an entry that never matches.
    genvar gi;
    generate
        for (gi = 0; gi < NoRules; gi++) begin : g_rule
            logic [AddrWidth-1:0] sh_start_q;
            logic [AddrWidth-1:0] sh_end_q;
            logic [IdxWidth-1:0]  sh_idx_q;
            logic [AddrWidth-1:0] act_start_q;
            logic [AddrWidth-1:0] act_end_q;
            logic [IdxWidth-1:0]  act_idx_q;
            logic                 sel;

            assign sel = wr_accept && (cfg_rule_i == RuleW'(gi));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sh_start_q  <= '1;
                    sh_end_q    <= '1;
                    sh_idx_q    <= '0;
                    act_start_q <= '1;
                    act_end_q   <= '1;
                    act_idx_q   <= '0;
                end else begin
                    if (sel) begin
                        sh_start_q <= cfg_start_i;
                        sh_end_q   <= cfg_end_i;
                        sh_idx_q   <= cfg_idx_i;
                    end
                    if (state_q == ST_COPY) begin
                        act_start_q <= sh_start_q;
                        act_end_q   <= sh_end_q;
                        act_idx_q   <= sh_idx_q;
                    end
                end
            end

            assign map_start_o[gi*AddrWidth +: AddrWidth] = act_start_q;
            assign map_end_o[gi*AddrWidth +: AddrWidth]   = act_end_q;
            assign map_idx_o[gi*IdxWidth +: IdxWidth]     = act_idx_q;
        end
    endgenerate

endmodule
